// File: rtl/serial_add_sched_pkg.sv
// Shared types for the serial add scheduler: the sequencer state enum and the
// requester-ID width helper.
package serial_add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } sched_state_t;

  // A single requester still needs a 1-bit ID field.
  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_adder.sv
// One-bit serial adder core: combinational sum/carry-out with a carry register
// that advances on vld and is cleared by the last bit of an operand stream.
module serial_bit_adder (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic a,
  input  logic b,
  input  logic last,
  output logic sum,
  output logic cout
);

  logic carry;

  assign sum  = a ^ b ^ carry;
  assign cout = (a & b) | (a & carry) | (b & carry);

  // Carry only moves while bits are streaming; the last bit leaves it clean for the next job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry <= 1'b0;
    end else if (vld) begin
      carry <= last ? 1'b0 : cout;
    end
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one bit-serial adder between N_REQ parallel requesters.
// Define SERIAL_ADD_SCHED_COUT_EN to add the res_cout output (carry out of the top bit).
module serial_add_scheduler
  import serial_add_sched_pkg::*;
#(
  parameter  int N_REQ = 2,
  parameter  int WIDTH = 8,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_rdy,
  output logic                     res_vld,
  input  logic                     res_rdy,
  output logic [ID_W-1:0]          res_id,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     busy
`ifdef SERIAL_ADD_SCHED_COUT_EN
  ,
  output logic                     res_cout
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  sched_state_t state, state_nxt;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic             accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  id_q;

  logic core_vld, core_a, core_b, core_last, core_sum, core_cout;

  // Round-robin scan: first pass from rr_ptr upward, second pass wraps to the lowest index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && req_vld[i] && (ID_W'(i) >= rr_ptr)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && req_vld[i]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = (state == IDLE) && grant_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = RESP;
      RESP:    if (res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_rdy   = '0;
    core_vld  = 1'b0;
    core_a    = 1'b0;
    core_b    = 1'b0;
    core_last = 1'b0;
    res_vld   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_found) req_rdy[grant_idx] = 1'b1;
      end
      SHIFT: begin
        core_vld  = 1'b1;
        core_a    = a_sh[0];
        core_b    = b_sh[0];
        core_last = (cnt == CNT_LAST);
      end
      RESP: begin
        res_vld = 1'b1;
      end
      default: ;
    endcase
  end

  // Sum bits enter at the MSB and walk down, so bit k lands at k after WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      id_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh <= sel_a;
            b_sh <= sel_b;
            cnt  <= '0;
            id_q <= grant_idx;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {core_sum, sum_sh[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == ID_LAST) ? '0 : grant_idx + 1'b1;
    end
  end

  assign res_sum = sum_sh;
  assign res_id  = id_q;

`ifdef SERIAL_ADD_SCHED_COUT_EN
  // The core clears its carry on the last bit, so sample the top carry-out in that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cout <= 1'b0;
    end else if (core_last) begin
      res_cout <= core_cout;
    end
  end
`else
  logic cout_unused;
  assign cout_unused = core_cout;
`endif

  serial_bit_adder u_core (
    .clk  (clk),
    .rst  (rst),
    .vld  (core_vld),
    .a    (core_a),
    .b    (core_b),
    .last (core_last),
    .sum  (core_sum),
    .cout (core_cout)
  );

endmodule
